dco_freq_meter: RTL
===================

# dco_freq_meter

Downstream measurement stage for the DCO output. It synchronises the free-running `dco_in` into the `clk` domain and counts its rising edges over a programmable gate window of `clk` cycles. It also records the cycle span from the first to the last counted edge, so firmware can derive the period as span/(count-1). Results are presented on a valid/ready interface and held until consumed.

## Interface
Parameters:
- `GATE_W`, 16, width of gate length and span counters
- `CNT_W`, 8, width of edge counter

Ports:
- `clk`  in  1  system clock
- `resetn`  in  1  reset, asynchronous, active-low
- `dco_in`  in  1  DCO output; treated as asynchronous
- `start`  in  1  single-cycle request to begin a measurement
- `clear`  in  1  synchronous abort; returns the block to IDLE
- `gate_len`  in  GATE_W  window length in `clk` cycles; sampled on accepted `start`
- `busy`  out  1  high in GATE and HOLD
- `meas_valid`  out  1  result available
- `meas_ready`  in  1  consumer accepts result
- `meas_count`  out  CNT_W  rising edges counted in window, saturating
- `meas_span`  out  GATE_W  cycles from first to last counted rise
- `meas_ovf`  out  1  edge counter saturated during window

## Operation
- Synchroniser:
  - `dco_in` passes through 2 flops (s1, s2); a third flop s3 holds the previous s2.
  - `rise = s2 & ~s3`.
  - No other logic samples `dco_in`.
- FSM states: IDLE, GATE, HOLD.
- IDLE:
  - `start=1` and `gate_len!=0`: load `remain=gate_len`; clear `edge_cnt`, `span_run`, `span_last`, `first_seen` and `ovf`; go to GATE.
  - `start` with `gate_len=0` is ignored.
- GATE, every cycle:
  - `remain` decrements.
  - If `rise`:
    - `edge_cnt` increments, saturating at 2^CNT_W-1.
    - An increment attempted at saturation sets `ovf`.
    - First rise: set `first_seen` and `span_run=0`.
    - Later rises: `span_last` is updated to the current `span_run`.
  - If `first_seen` is set: `span_run` increments, saturating at 2^GATE_W-1.
  - In the cycle with `remain==1`, that cycle's rise is still counted. The updated values load into the `meas_*` registers and the FSM goes to HOLD.
- HOLD:
  - `meas_valid=1`; all `meas_*` outputs are stable.
  - When `meas_valid & meas_ready`, the FSM goes to IDLE and `meas_valid` deasserts next cycle.
- `start` is ignored outside IDLE, including on the handshake cycle.
- `clear`:
  - From any state, goes to IDLE next cycle and drops `meas_valid`.
  - `meas_*` data keeps its last value.
  - `clear` has priority over `start` and over the handshake.
- Fewer than 2 rises in the window: `meas_span=0`.
- Reset:
  - FSM in IDLE; all synchroniser flops, counters and outputs are 0.
  - `busy=0`, `meas_valid=0`, `meas_count=0`, `meas_span=0`, `meas_ovf=0`.
  - Reset mid-measurement discards it entirely.

## Timing
- `start` accepted at edge t: GATE covers the cycles after edges t+1 … t+gate_len.
  - `busy=1` from t+1.
  - `meas_valid=1` from edge t+gate_len.
- Earliest next `start` is the cycle after the handshake edge.
- `dco_in` latency: a rise sampled into s1 at edge k is seen as `rise` in the cycle after edge k+1. Edges within 2 cycles of window start or end may fall either side; the bench aligns them deterministically.
- Max countable `dco_in` frequency: `clk`/2. Both `dco_in` high and low phases must be ≥1 `clk` cycle.

## Test plan
- Reset value check: assert `resetn=0` mid-GATE with `dco_in` toggling -> all outputs 0 next cycle. After release, `start`, `gate_len=10`, `dco_in=0` -> `meas_valid` 10 cycles later with count=0, span=0, ovf=0.
- Nominal measurement: `gate_len=100`, `dco_in` period 8 cycles, first `rise` in window cycle 3 -> rises in cycles 3,11,…,99. Expect count=13, span=96, ovf=0.
- Saturation: `dco_in` toggling every cycle (`rise` every 2 cycles), `gate_len=1000` -> count=255, ovf=1, span equal to cycles between first and last rise.
- Backpressure: `meas_ready=0` for 20 cycles after valid, with `start` pulsed during HOLD -> valid and data stable, `start` ignored. `meas_ready=1` -> IDLE, valid low next cycle.
- Abort: `clear` at GATE cycle 50 of 100 -> IDLE next cycle, no `meas_valid`. A new `start` is accepted normally and produces fresh results.
- Corner cases:
  - `gate_len=0` -> start ignored, `busy` stays 0.
  - `gate_len=1` with a rise in that cycle -> count=1, span=0, valid 1 cycle after GATE entry.

Source files
------------

// File: rtl/dco_freq_meter.sv
// DCO frequency meter: counts synchronised dco_in rising edges over a gate window of clk cycles.
// Also records the span, in clk cycles, from the first to the last counted edge.
module dco_freq_meter #(
  parameter int GATE_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              dco_in,
  input  logic              start,
  input  logic              clear,
  input  logic [GATE_W-1:0] gate_len,
  output logic              busy,
  output logic              meas_valid,
  input  logic              meas_ready,
  output logic [CNT_W-1:0]  meas_count,
  output logic [GATE_W-1:0] meas_span,
  output logic              meas_ovf
);

  // state   | meaning
  // IDLE    | waiting for start with a non-zero gate length
  // GATE    | window open, counting rises and tracking span
  // HOLD    | result presented, waiting for meas_ready
  typedef enum logic [1:0] {ST_IDLE, ST_GATE, ST_HOLD} state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [GATE_W-1:0] SPAN_MAX = '1;

  state_t state, state_nxt;
  logic   s1, s2, s3, rise;
  logic   load, capture;

  logic [GATE_W-1:0] remain;
  logic [CNT_W-1:0]  edge_cnt, cnt_nxt;
  logic [GATE_W-1:0] span_run, span_run_nxt, span_last, span_last_nxt, span_inc;
  logic              first_seen, first_nxt, ovf, ovf_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= dco_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && (gate_len != '0)) begin
          state_nxt = ST_GATE;
          load      = 1'b1;
        end
      end
      ST_GATE: begin
        if (remain == GATE_W'(1)) begin
          state_nxt = ST_HOLD;
          capture   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (meas_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Abort wins over everything and leaves the previous result untouched
    if (clear) begin
      state_nxt = ST_IDLE;
      load      = 1'b0;
      capture   = 1'b0;
    end
  end

  always_comb begin
    cnt_nxt       = edge_cnt;
    ovf_nxt       = ovf;
    first_nxt     = first_seen;
    span_run_nxt  = span_run;
    span_last_nxt = span_last;
    span_inc      = (span_run == SPAN_MAX) ? span_run : span_run + 1'b1;
    if (first_seen) span_run_nxt = span_inc;
    if (rise) begin
      if (edge_cnt == CNT_MAX) ovf_nxt = 1'b1;
      else                     cnt_nxt = edge_cnt + 1'b1;
      if (!first_seen) begin
        first_nxt    = 1'b1;
        span_run_nxt = '0;
      end else begin
        // span_inc is the distance in cycles from the first rise to this one
        span_last_nxt = span_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      remain     <= '0;
      edge_cnt   <= '0;
      span_run   <= '0;
      span_last  <= '0;
      first_seen <= 1'b0;
      ovf        <= 1'b0;
      meas_count <= '0;
      meas_span  <= '0;
      meas_ovf   <= 1'b0;
    end else begin
      if (load) begin
        remain     <= gate_len;
        edge_cnt   <= '0;
        span_run   <= '0;
        span_last  <= '0;
        first_seen <= 1'b0;
        ovf        <= 1'b0;
      end else if (state == ST_GATE) begin
        remain     <= remain - 1'b1;
        edge_cnt   <= cnt_nxt;
        span_run   <= span_run_nxt;
        span_last  <= span_last_nxt;
        first_seen <= first_nxt;
        ovf        <= ovf_nxt;
      end
      if (capture) begin
        meas_count <= cnt_nxt;
        meas_span  <= span_last_nxt;
        meas_ovf   <= ovf_nxt;
      end
    end
  end

  assign busy       = (state != ST_IDLE);
  assign meas_valid = (state == ST_HOLD);

endmodule
